// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the data memory responder: access sizes, FSM states
// and byte-lane masks, plus small decode helpers.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_ILL  = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  localparam logic [3:0] LANE_MASK_BYTE = 4'b0001;
  localparam logic [3:0] LANE_MASK_HALF = 4'b0011;
  localparam logic [3:0] LANE_MASK_WORD = 4'b1111;

  function automatic logic [3:0] lane_mask(mem_size_e sz, logic [1:0] off);
    case (sz)
      SIZE_BYTE: return LANE_MASK_BYTE << off;
      SIZE_HALF: return LANE_MASK_HALF << {off[1], 1'b0};
      SIZE_WORD: return LANE_MASK_WORD;
      default:   return 4'b0000;
    endcase
  endfunction

  // The illegal size encoding is reported through the same path as misalignment.
  function automatic logic misaligned(mem_size_e sz, logic [1:0] off);
    case (sz)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return off[0];
      SIZE_WORD: return |off;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between a processor (master) and the data memory
// responder (slave).
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] ADDR;
  logic [31:0] DOUT;
  logic        W;
  logic [1:0]  size;
  logic        ld_unsigned;
  logic [31:0] DIN;
  logic        rsp_valid;
  logic        err;

  modport master (
    output req_valid, ADDR, DOUT, W, size, ld_unsigned,
    input  req_ready, DIN, rsp_valid, err
  );

  modport slave (
    input  req_valid, ADDR, DOUT, W, size, ld_unsigned,
    output req_ready, DIN, rsp_valid, err
  );
endinterface

// File: rtl/mem_load_align.sv
// Load data extraction: picks the addressed lanes of a memory word, moves them
// to bit 0 and sign- or zero-extends them.
module mem_load_align
  import riscv_mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  mem_size_e   size_i,
  input  logic        ld_unsigned_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;
  logic        sign_bit;

  always_comb begin
    shifted  = word_i >> {addr_lo_i, 3'b000};
    sign_bit = 1'b0;
    data_o   = '0;
    case (size_i)
      SIZE_BYTE: begin
        sign_bit = ~ld_unsigned_i & shifted[7];
        data_o   = {{24{sign_bit}}, shifted[7:0]};
      end
      SIZE_HALF: begin
        sign_bit = ~ld_unsigned_i & shifted[15];
        data_o   = {{16{sign_bit}}, shifted[15:0]};
      end
      SIZE_WORD: data_o = shifted;
      default:   data_o = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder: accepts one request, waits a fixed
// number of cycles, then answers with aligned load data or performs a store.
module data_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);

  localparam int          AW          = $clog2(DEPTH_WORDS);
  localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_WORDS);
  localparam logic [2:0]  WAIT_INIT   = 3'(WAIT_STATES);

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [AW+1:0] addr_q;
  logic [31:0] dout_q;
  logic        w_q;
  mem_size_e   size_q;
  logic        uns_q;
  logic        fault_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic        err_q;
  logic [31:0] din_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  mem_size_e   in_size;
  logic        in_fault_d;
  logic        idle;
  logic [AW-1:0] eff_idx;
  logic [1:0]  eff_off;
  mem_size_e   eff_size;
  logic        eff_uns;
  logic        eff_w;
  logic        eff_fault;
  logic [31:0] rd_word;
  logic [31:0] ld_data;
  logic [31:0] rsp_din_d;

  // With zero wait states the response is formed on the accept edge, so the
  // read side looks at the live bus while idle and the captured request after.
  always_comb begin
    in_size    = mem_size_e'(bus.size);
    in_fault_d = misaligned(in_size, bus.ADDR[1:0]) ||
                 ({2'b00, bus.ADDR[31:2]} >= DEPTH_LIMIT);
    idle       = (state_q == ST_IDLE);
    eff_idx    = idle ? bus.ADDR[AW+1:2]  : addr_q[AW+1:2];
    eff_off    = idle ? bus.ADDR[1:0]     : addr_q[1:0];
    eff_size   = idle ? in_size           : size_q;
    eff_uns    = idle ? bus.ld_unsigned   : uns_q;
    eff_w      = idle ? bus.W             : w_q;
    eff_fault  = idle ? in_fault_d        : fault_q;
    rd_word    = mem_q[eff_idx];
  end

  mem_load_align u_load_align (
    .word_i        (rd_word),
    .addr_lo_i     (eff_off),
    .size_i        (eff_size),
    .ld_unsigned_i (eff_uns),
    .data_o        (ld_data)
  );

  assign rsp_din_d = (eff_w || eff_fault) ? 32'h0 : ld_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      dout_q      <= '0;
      w_q         <= 1'b0;
      size_q      <= SIZE_BYTE;
      uns_q       <= 1'b0;
      fault_q     <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      din_q       <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      din_q       <= '0;
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            addr_q      <= bus.ADDR[AW+1:0];
            dout_q      <= bus.DOUT;
            w_q         <= bus.W;
            size_q      <= in_size;
            uns_q       <= bus.ld_unsigned;
            fault_q     <= in_fault_d;
            cnt_q       <= WAIT_INIT;
            req_ready_q <= 1'b0;
            if (WAIT_STATES == 0) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              err_q       <= in_fault_d;
              din_q       <= rsp_din_d;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            err_q       <= fault_q;
            din_q       <= rsp_din_d;
          end
        end
        ST_RESP: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.err       = err_q;
  assign bus.DIN       = din_q;

  // Store path: right-aligned store data is replicated across lanes, and the
  // lane mask picks which bytes land. The write happens on the RESP cycle.
  logic       wr_en;
  logic [3:0] wr_mask;
  logic [7:0] wr_lane [4];

  assign wr_en   = (state_q == ST_RESP) && w_q && !fault_q && !reset;
  assign wr_mask = lane_mask(size_q, addr_q[1:0]);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wr_lane[gi] = (size_q == SIZE_BYTE) ? dout_q[7:0] :
                         (size_q == SIZE_HALF) ? dout_q[8*(gi%2) +: 8] :
                                                 dout_q[8*gi +: 8];
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_mask[i]) begin
          mem_q[addr_q[AW+1:2]][8*i +: 8] <= wr_lane[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a one-wait-state instance for single
// transactions and reset abort, a zero-wait-state instance for back-to-back traffic.
module tb_data_mem_responder;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;
  localparam int         NB2B = 9;

  logic clk = 1'b0;
  logic rst1;
  logic rst0;

  always #5 clk = ~clk;

  data_mem_responder_if m1 ();
  data_mem_responder_if m0 ();

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) dut1 (
    .clock (clk),
    .reset (rst1),
    .bus   (m1.slave)
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
    .clock (clk),
    .reset (rst0),
    .bus   (m0.slave)
  );

  typedef struct {
    logic [31:0] din;
    logic        err;
  } exp_t;

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] d;
    logic        u;
    logic [31:0] ed;
    logic        ee;
  } vec_t;

  exp_t q1[$];
  exp_t q0[$];
  vec_t tbl[NB2B];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check32(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(string tag, logic obs, logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic vec_t mk(logic w, logic [1:0] sz, logic [31:0] a, logic [31:0] d,
                              logic u, logic [31:0] ed, logic ee);
    vec_t v;
    v.w = w; v.sz = sz; v.a = a; v.d = d; v.u = u; v.ed = ed; v.ee = ee;
    return v;
  endfunction

  task automatic drive1(logic w, logic [1:0] sz, logic [31:0] a, logic [31:0] d, logic u);
    m1.W = w; m1.size = sz; m1.ADDR = a; m1.DOUT = d; m1.ld_unsigned = u;
  endtask

  // One complete transaction on the one-wait-state instance.
  task automatic req1(string tag, logic w, logic [1:0] sz, logic [31:0] a, logic [31:0] d,
                      logic u, logic [31:0] exp_din, logic exp_err);
    exp_t e;
    exp_t got;
    int   k;
    int   lat;
    @(negedge clk);
    drive1(w, sz, a, d, u);
    m1.req_valid = 1'b1;
    k = 0;
    while (!m1.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check1({tag, " ready"}, m1.req_ready, 1'b1);
    e.din = exp_din;
    e.err = exp_err;
    q1.push_back(e);
    @(negedge clk);
    m1.req_valid   = 1'b0;
    m1.ADDR        = $urandom;
    m1.DOUT        = $urandom;
    m1.W           = 1'($urandom);
    m1.size        = 2'($urandom);
    m1.ld_unsigned = 1'($urandom);
    check1({tag, " busy"}, m1.req_ready, 1'b0);
    lat = 1;
    while (!m1.rsp_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check32({tag, " latency"}, 32'(lat), 32'd2);
    if (m1.rsp_valid && q1.size() > 0) begin
      got = q1.pop_front();
      check32({tag, " din"}, m1.DIN, got.din);
      check1({tag, " err"}, m1.err, got.err);
      $display("req %s: W=%b size=%b addr=%h din=%h err=%b", tag, w, sz, a, m1.DIN, m1.err);
    end else begin
      check1({tag, " rsp seen"}, m1.rsp_valid, 1'b1);
      if (q1.size() > 0) void'(q1.pop_back());
    end
    @(negedge clk);
    check1({tag, " pulse"}, m1.rsp_valid, 1'b0);
    check32({tag, " din idle"}, m1.DIN, 32'h0);
  endtask

  task automatic apply0(int i);
    m0.W = tbl[i].w; m0.size = tbl[i].sz; m0.ADDR = tbl[i].a;
    m0.DOUT = tbl[i].d; m0.ld_unsigned = tbl[i].u;
    m0.req_valid = 1'b1;
  endtask

  initial begin
    exp_t e;
    exp_t got;
    int   idx;
    int   nacc;
    int   nrsp;
    int   last_acc;
    bit   pend;

    rst1 = 1'b0;
    rst0 = 1'b0;
    m1.req_valid = 1'b0; drive1(1'b0, SZ_W, 32'h0, 32'h0, 1'b0);
    m0.req_valid = 1'b0; m0.W = 1'b0; m0.size = SZ_W; m0.ADDR = 32'h0;
    m0.DOUT = 32'h0; m0.ld_unsigned = 1'b0;
    #1;
    rst1 = 1'b1;
    rst0 = 1'b1;
    repeat (2) @(negedge clk);
    check1("reset ready", m1.req_ready, 1'b1);
    check1("reset rsp_valid", m1.rsp_valid, 1'b0);
    check1("reset err", m1.err, 1'b0);
    check32("reset din", m1.DIN, 32'h0);
    check1("reset ready0", m0.req_ready, 1'b1);
    rst1 = 1'b0;
    rst0 = 1'b0;
    @(negedge clk);
    check1("post reset ready", m1.req_ready, 1'b1);

    req1("st_w_10",   1'b1, SZ_W, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    req1("ld_w_10",   1'b0, SZ_W, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);

    req1("st_w_base", 1'b1, SZ_W, 32'h10, 32'h11223344, 1'b0, 32'h0, 1'b0);
    req1("st_b_13",   1'b1, SZ_B, 32'h13, 32'hAAAAAA80, 1'b0, 32'h0, 1'b0);
    req1("ld_bs_13",  1'b0, SZ_B, 32'h13, 32'h0, 1'b0, 32'hFFFFFF80, 1'b0);
    req1("ld_bu_13",  1'b0, SZ_B, 32'h13, 32'h0, 1'b1, 32'h00000080, 1'b0);
    req1("ld_w_mix",  1'b0, SZ_W, 32'h10, 32'h0, 1'b0, 32'h80223344, 1'b0);

    req1("ld_h_11",   1'b0, SZ_H, 32'h11, 32'h0, 1'b0, 32'h0, 1'b1);
    req1("ld_w_12",   1'b0, SZ_W, 32'h12, 32'h0, 1'b0, 32'h0, 1'b1);
    req1("st_x_10",   1'b1, SZ_X, 32'h10, 32'h0, 1'b0, 32'h0, 1'b1);
    req1("ld_x_10",   1'b0, SZ_X, 32'h10, 32'h0, 1'b1, 32'h0, 1'b1);
    req1("st_h_11",   1'b1, SZ_H, 32'h11, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b1);
    req1("ld_w_keep", 1'b0, SZ_W, 32'h10, 32'h0, 1'b0, 32'h80223344, 1'b0);

    req1("ld_hs_12",  1'b0, SZ_H, 32'h12, 32'h0, 1'b0, 32'hFFFF8022, 1'b0);
    req1("ld_bs_11",  1'b0, SZ_B, 32'h11, 32'h0, 1'b0, 32'h00000033, 1'b0);
    req1("st_h_12",   1'b1, SZ_H, 32'h12, 32'h0000BEEF, 1'b0, 32'h0, 1'b0);
    req1("ld_w_half", 1'b0, SZ_W, 32'h10, 32'h0, 1'b0, 32'hBEEF3344, 1'b0);
    req1("ld_hu_12",  1'b0, SZ_H, 32'h12, 32'h0, 1'b1, 32'h0000BEEF, 1'b0);

    req1("st_w_0",    1'b1, SZ_W, 32'h0, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0);
    req1("st_oor",    1'b1, SZ_W, 32'h1000, 32'h12345678, 1'b0, 32'h0, 1'b1);
    req1("ld_w_0",    1'b0, SZ_W, 32'h0, 32'h0, 1'b0, 32'hCAFEF00D, 1'b0);
    req1("st_w_top",  1'b1, SZ_W, 32'hFFC, 32'h5A5A5A5A, 1'b0, 32'h0, 1'b0);
    req1("ld_w_top",  1'b0, SZ_W, 32'hFFC, 32'h0, 1'b0, 32'h5A5A5A5A, 1'b0);
    req1("ld_oor",    1'b0, SZ_W, 32'h1000, 32'h0, 1'b0, 32'h0, 1'b1);

    // Abort a store while it sits in WAIT.
    req1("st_w_20",   1'b1, SZ_W, 32'h20, 32'h01020304, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    drive1(1'b1, SZ_W, 32'h20, 32'hFFFFFFFF, 1'b0);
    m1.req_valid = 1'b1;
    check1("abort accept", m1.req_ready, 1'b1);
    @(negedge clk);
    m1.req_valid = 1'b0;
    check1("abort in wait", m1.req_ready, 1'b0);
    rst1 = 1'b1;
    #1;
    check1("abort ready now", m1.req_ready, 1'b1);
    check1("abort rsp now", m1.rsp_valid, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check1("abort no rsp", m1.rsp_valid, 1'b0);
    end
    rst1 = 1'b0;
    @(negedge clk);
    check1("abort no rsp late", m1.rsp_valid, 1'b0);
    $display("req abort: store 0x20 discarded by reset");
    req1("ld_w_20",   1'b0, SZ_W, 32'h20, 32'h0, 1'b0, 32'h01020304, 1'b0);

    // Back-to-back traffic with req_valid held high on the zero-wait instance.
    tbl[0] = mk(1'b1, SZ_W, 32'h40, 32'hA5A51234, 1'b0, 32'h0, 1'b0);
    tbl[1] = mk(1'b1, SZ_W, 32'h44, 32'h000080FF, 1'b0, 32'h0, 1'b0);
    tbl[2] = mk(1'b0, SZ_W, 32'h40, 32'h0, 1'b0, 32'hA5A51234, 1'b0);
    tbl[3] = mk(1'b0, SZ_B, 32'h44, 32'h0, 1'b0, 32'hFFFFFFFF, 1'b0);
    tbl[4] = mk(1'b0, SZ_H, 32'h44, 32'h0, 1'b0, 32'hFFFF80FF, 1'b0);
    tbl[5] = mk(1'b0, SZ_X, 32'h40, 32'h0, 1'b0, 32'h0, 1'b1);
    tbl[6] = mk(1'b0, SZ_H, 32'h42, 32'h0, 1'b1, 32'h0000A5A5, 1'b0);
    tbl[7] = mk(1'b1, SZ_B, 32'h47, 32'h0000007F, 1'b0, 32'h0, 1'b0);
    tbl[8] = mk(1'b0, SZ_W, 32'h44, 32'h0, 1'b0, 32'h7F0080FF, 1'b0);

    idx = 0; nacc = 0; nrsp = 0; last_acc = 0; pend = 1'b0;
    @(negedge clk);
    apply0(0);
    for (int cyc = 0; cyc < 60 && nrsp < NB2B; cyc++) begin
      if (m0.rsp_valid) begin
        nrsp++;
        if (q0.size() == 0) begin
          check1("b2b extra rsp", m0.rsp_valid, 1'b0);
        end else begin
          got = q0.pop_front();
          check32($sformatf("b2b din %0d", nrsp - 1), m0.DIN, got.din);
          check1($sformatf("b2b err %0d", nrsp - 1), m0.err, got.err);
          $display("b2b rsp %0d: din=%h err=%b", nrsp - 1, m0.DIN, m0.err);
        end
      end
      if (pend) begin
        pend = 1'b0;
        idx++;
        if (idx < NB2B) apply0(idx);
        else m0.req_valid = 1'b0;
      end
      if (m0.req_valid && m0.req_ready) begin
        e.din = tbl[idx].ed;
        e.err = tbl[idx].ee;
        q0.push_back(e);
        if (nacc > 0) check32("b2b accept spacing", 32'(cyc - last_acc), 32'd2);
        last_acc = cyc;
        nacc++;
        pend = 1'b1;
      end
      @(negedge clk);
    end
    m0.req_valid = 1'b0;
    repeat (4) begin
      check1("b2b quiet", m0.rsp_valid, 1'b0);
      @(negedge clk);
    end
    check32("b2b accepts", 32'(nacc), 32'(NB2B));
    check32("b2b responses", 32'(nrsp), 32'(NB2B));
    check32("b2b queue empty", 32'(q0.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words stored (power of two).
REQ-002 The block SHALL have parameter WAIT_STATES, default 1, extra cycles between request accept and response (0..7).
REQ-003 The block SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port req_valid, input, 1, processor presents a request.
REQ-006 The block SHALL have port req_ready, output, 1, responder accepts a request this cycle.
REQ-007 The block SHALL have port ADDR, input, 32, byte address of the request.
REQ-008 The block SHALL have port DOUT, input, 32, processor write data, right-aligned.
REQ-009 The block SHALL have port W, input, 1, 1 = store, 0 = load.
REQ-010 The block SHALL have port size, input, 2, access size: 00 byte, 01 half, 10 word; 11 is illegal.
REQ-011 The block SHALL have port ld_unsigned, input, 1, zero-extend loads when 1, sign-extend when 0.
REQ-012 The block SHALL have port DIN, output, 32, load data to processor, right-aligned and extended.
REQ-013 The block SHALL have port rsp_valid, output, 1, one-cycle pulse marking response completion.
REQ-014 The block SHALL have port err, output, 1, valid with rsp_valid; flags a faulted request.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 In IDLE with req_valid=1, the block SHALL capture ADDR, DOUT, W, size and ld_unsigned into request registers, load the wait counter with WAIT_STATES, and go to WAIT, or go to RESP when WAIT_STATES=0.
REQ-017 In WAIT the counter SHALL decrement once per cycle, and the block SHALL go to RESP on the cycle the counter reaches 0.
REQ-018 In RESP, rsp_valid SHALL be 1 for exactly one cycle, then the block SHALL return to IDLE; accept-to-rsp_valid latency is WAIT_STATES+1 cycles.
REQ-019 Input changes outside the accept cycle SHALL be ignored; only one request SHALL be outstanding.
REQ-020 A request SHALL fault (err=1) when size=11, half is not 2-byte aligned, word is not 4-byte aligned, or ADDR[31:2] >= DEPTH_WORDS.
REQ-021 A faulted request SHALL not modify storage and SHALL return DIN=0.
REQ-022 A store SHALL write only the addressed byte lanes (byte: lane ADDR[1:0]; half: lanes ADDR[1]*2..+1; word: all) of word ADDR[31:2] on the RESP cycle; DIN SHALL be 0 for stores.
REQ-023 A load SHALL select the addressed lanes, shift them to bit 0, and sign- or zero-extend them to 32 bits according to ld_unsigned; a word load SHALL ignore ld_unsigned.
REQ-024 DIN and err SHALL be registered, valid only while rsp_valid=1, and 0 otherwise.
REQ-025 Little-endian byte order SHALL apply: lane 0 is bits 7:0.

Reset
REQ-026 Asserting reset at any time SHALL immediately force IDLE, req_ready=1, rsp_valid=0, err=0, DIN=0, counter=0, and clear the request registers.
REQ-027 A request in flight during reset SHALL be discarded with no storage write and no response; storage contents are not reset.

Structure
REQ-028 Shared package riscv_mem_pkg SHALL hold the size encodings, the FSM state enum, and the lane-mask constants.
REQ-029 Load extraction and extension SHALL be one sub-module, mem_load_align (inputs: word, ADDR[1:0], size, ld_unsigned; output: 32-bit extended data).
REQ-030 Storage SHALL be a word array of DEPTH_WORDS with per-byte write enables.

Verification
REQ-031 The bench SHALL cover: WAIT_STATES=1, store word 0xDEADBEEF at 0x10, then load word 0x10 -> rsp_valid 2 cycles after each accept, DIN=0xDEADBEEF, err=0.
REQ-032 The bench SHALL cover: store byte 0x80 at 0x13 over word 0x11223344 -> signed byte load at 0x13 returns 0xFFFFFF80, unsigned returns 0x00000080, and word 0x10 reads 0x80223344.
REQ-033 The bench SHALL cover: half load at 0x11, word load at 0x12, and size=11 -> err=1, DIN=0, storage unchanged.
REQ-034 The bench SHALL cover: DEPTH_WORDS=1024, store to 0x1000 -> err=1, and word 0 is unchanged.
REQ-035 The bench SHALL cover: reset asserted mid-WAIT of a store to 0x20 -> no rsp_valid, word 0x20 unchanged, and req_ready=1 immediately.
REQ-036 The bench SHALL cover: WAIT_STATES=0 with back-to-back req_valid held high -> accepts every 2 cycles, each request answered exactly once.
